vga_scan_out: RTL

Display back-end stage for the rainbow frame-buffer test. It generates 640x480@60 VGA raster timing on the pixel clock. It issues per-pixel read requests (x, y) to the frame-buffer RAM and registers the returned 15-bit RGB555 word. It then drives hsync/vsync/de and 8-bit-per-channel colour, with the sync signals delay-matched to the RAM read latency.

---
 rtl/vga_scan_out.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// VGA raster generator and scan-out stage: issues frame-buffer reads per visible pixel
// and drives colour plus sync/de, with the sync signals delayed to match the RAM read latency.
module vga_scan_out #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned RD_LAT   = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [14:0] rgb_in,
    output logic        rd_en,
    output logic [9:0]  rd_x,
    output logic [9:0]  rd_y,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] hcnt, vcnt;
    logic [CW-1:0] hcnt_nxt, vcnt_nxt;
    logic          active0, hs0, vs0, fs0;
    logic [RD_LAT:0] act_dly, hs_dly, vs_dly, fs_dly;
    logic          tap_active;

    // Raster counter next state; en low parks the raster at the origin
    always_comb begin
        hcnt_nxt = '0;
        vcnt_nxt = '0;
        if (en) begin
            if (hcnt == CW'(H_TOTAL - 1)) begin
                hcnt_nxt = '0;
                vcnt_nxt = (vcnt == CW'(V_TOTAL - 1)) ? '0 : vcnt + CW'(1);
            end else begin
                hcnt_nxt = hcnt + CW'(1);
                vcnt_nxt = vcnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
        end
    end

    // Stage-0 raster flags, all inactive while disabled
    always_comb begin
        active0 = en && (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
        hs0     = en && (hcnt >= CW'(HS_START)) && (hcnt < CW'(HS_END));
        vs0     = en && (vcnt >= CW'(VS_START)) && (vcnt < CW'(VS_END));
        fs0     = en && (hcnt == '0) && (vcnt == '0);
    end

    // Read request plus flag delay line; the last tap lines up with rgb_in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_x    <= '0;
            rd_y    <= '0;
            act_dly <= '0;
            hs_dly  <= '0;
            vs_dly  <= '0;
            fs_dly  <= '0;
        end else begin
            rd_en <= active0;
            if (active0) begin
                rd_x <= hcnt;
                rd_y <= vcnt;
            end
            act_dly <= {act_dly[RD_LAT-1:0], active0};
            hs_dly  <= {hs_dly[RD_LAT-1:0], hs0};
            vs_dly  <= {vs_dly[RD_LAT-1:0], vs0};
            fs_dly  <= {fs_dly[RD_LAT-1:0], fs0};
        end
    end

    assign tap_active = act_dly[RD_LAT];

    // Output register: RGB555 expanded to 8 bits by MSB replication, blanked outside active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            de          <= tap_active;
            hsync       <= hs_dly[RD_LAT] ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_dly[RD_LAT] ? SYNC_POL : ~SYNC_POL;
            frame_start <= fs_dly[RD_LAT];
            vga_r       <= tap_active ? {rgb_in[14:10], rgb_in[14:12]} : 8'h00;
            vga_g       <= tap_active ? {rgb_in[9:5],   rgb_in[9:7]}   : 8'h00;
            vga_b       <= tap_active ? {rgb_in[4:0],   rgb_in[4:2]}   : 8'h00;
        end
    end

endmodule
